// File: rtl/card_dealer.sv
// Card source for the blackjack game: draws one card per request, without
// replacement, from a shoe of NUM_DECKS decks using a 16-bit LFSR.
module card_dealer #(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ_I,
  input  logic       SHUFFLE_I,
  output logic       READY_O,
  output logic       CARD_VALID_O,
  output logic [3:0] CARD_O,
  output logic [3:0] RANK_O,
  output logic [7:0] CARDS_LEFT_O,
  output logic       DECK_EMPTY_O
);

  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [4:0]  FULL_CNT  = 5'(4 * NUM_DECKS);
  localparam logic [7:0]  FULL_LEFT = 8'(52 * NUM_DECKS);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_SCAN, S_EMIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lfsr;
  logic [4:0]  r_cnt [13];
  logic [7:0]  r_left;
  logic [3:0]  r_probe;
  logic [3:0]  w_probe_nxt;
  logic [3:0]  r_rank;
  logic [3:0]  r_card;
  logic [3:0]  w_lfsr_mod;
  logic [3:0]  w_cand;
  logic        w_cand_avail;
  logic        w_probe_avail;
  logic        w_load;
  logic        w_dec;
  logic        w_fb;

  function automatic logic [3:0] next_rank(input logic [3:0] rk);
    return (rk == 4'd13) ? 4'd1 : rk + 4'd1;
  endfunction

  function automatic logic [3:0] bj_value(input logic [3:0] rk);
    return (rk > 4'd10) ? 4'd10 : rk;
  endfunction

  // Counters are stored 0-based, so rank r lives at index r-1.
  assign w_lfsr_mod    = (r_lfsr[3:0] >= 4'd13) ? r_lfsr[3:0] - 4'd13 : r_lfsr[3:0];
  assign w_cand        = w_lfsr_mod + 4'd1;
  assign w_cand_avail  = (r_cnt[w_cand - 4'd1] != 5'd0);
  assign w_probe_avail = (r_cnt[r_probe - 4'd1] != 5'd0);
  assign w_fb          = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_dec         = (r_state == S_EMIT) && !SHUFFLE_I;

  assign READY_O      = (r_state == S_IDLE) && (r_left != 8'd0);
  assign CARD_VALID_O = (r_state == S_EMIT);
  assign CARD_O       = r_card;
  assign RANK_O       = r_rank;
  assign CARDS_LEFT_O = r_left;
  assign DECK_EMPTY_O = (r_left == 8'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_probe <= 4'd1;
    end else begin
      r_state <= w_state_nxt;
      r_probe <= w_probe_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_probe_nxt = r_probe;
    w_load      = 1'b0;
    if (SHUFFLE_I) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (REQ_I && READY_O) w_state_nxt = S_DRAW;
        S_DRAW: begin
          if (w_cand_avail) begin
            w_state_nxt = S_EMIT;
            w_probe_nxt = w_cand;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_SCAN;
            w_probe_nxt = next_rank(w_cand);
          end
        end
        S_SCAN: begin
          if (w_probe_avail) begin
            w_state_nxt = S_EMIT;
            w_load      = 1'b1;
          end else begin
            w_probe_nxt = next_rank(r_probe);
          end
        end
        S_EMIT:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // LFSR free-runs regardless of state or shuffle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_lfsr <= LFSR_INIT;
    else        r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rank <= 4'd0;
      r_card <= 4'd0;
    end else if (w_load) begin
      r_rank <= w_probe_nxt;
      r_card <= bj_value(w_probe_nxt);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 13; i++) r_cnt[i] <= FULL_CNT;
      r_left <= FULL_LEFT;
    end else if (SHUFFLE_I) begin
      for (int i = 0; i < 13; i++) r_cnt[i] <= FULL_CNT;
      r_left <= FULL_LEFT;
    end else if (w_dec) begin
      r_cnt[r_rank - 4'd1] <= r_cnt[r_rank - 4'd1] - 5'd1;
      r_left               <= r_left - 8'd1;
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Randomized scoreboard bench for card_dealer against a shoe-level reference model.
module tb_card_dealer;
  localparam int          ND        = 1;
  localparam logic [15:0] SD        = 16'hACE1;
  localparam int          FULL_LEFT = 52 * ND;
  localparam int          FULL_CNT  = 4 * ND;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       REQ_I = 1'b0;
  logic       SHUFFLE_I = 1'b0;
  logic       READY_O, CARD_VALID_O, DECK_EMPTY_O;
  logic [3:0] CARD_O, RANK_O;
  logic [7:0] CARDS_LEFT_O;

  always #5 CLK = ~CLK;

  card_dealer #(.NUM_DECKS(ND), .SEED(SD)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_I(REQ_I), .SHUFFLE_I(SHUFFLE_I),
    .READY_O(READY_O), .CARD_VALID_O(CARD_VALID_O), .CARD_O(CARD_O),
    .RANK_O(RANK_O), .CARDS_LEFT_O(CARDS_LEFT_O), .DECK_EMPTY_O(DECK_EMPTY_O)
  );

  typedef struct {int rank; int card; int cyc;} exp_t;
  exp_t        sb[$];
  int          chk = 0;
  int          err = 0;
  logic [15:0] m_lfsr;
  int          m_cnt[13];
  int          m_left;
  bit          m_inflight;
  int          m_done;
  int          edge_n;
  int          n_strobe;
  int          hist_rank[14];
  int          hist_card[11];
  int          log_q[$];
  int          run1[$];

  task automatic check(input string name, input int act, input int req);
    chk++;
    if (act != req) begin
      err++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic bit m_ready();
    return !m_inflight && (m_left != 0);
  endfunction

  task automatic model_reset();
    m_lfsr = SD;
    for (int i = 0; i < 13; i++) m_cnt[i] = FULL_CNT;
    m_left = FULL_LEFT;
    m_inflight = 0;
    edge_n = 0;
    sb.delete();
  endtask

  // One rising edge of the shoe: finish a pending card, shuffle, or accept a draw.
  task automatic model_step(input bit req, input bit shuf);
    bit rdy;
    int r, rk, s;
    exp_t e;
    rdy = m_ready();
    edge_n++;
    m_lfsr = lfsr_next(m_lfsr);
    if (m_inflight && edge_n == m_done) begin
      m_inflight = 0;
      m_left--;
    end
    if (shuf) begin
      if (m_inflight) begin
        void'(sb.pop_back());
        m_inflight = 0;
      end
      for (int i = 0; i < 13; i++) m_cnt[i] = FULL_CNT;
      m_left = FULL_LEFT;
    end else if (req && rdy) begin
      r = int'(m_lfsr[3:0]);
      rk = ((r >= 13) ? r - 13 : r) + 1;
      s = 0;
      while (m_cnt[rk-1] == 0) begin
        rk = (rk == 13) ? 1 : rk + 1;
        s++;
      end
      m_cnt[rk-1]--;
      e.rank = rk;
      e.card = (rk > 10) ? 10 : rk;
      e.cyc  = edge_n + 1 + s;
      sb.push_back(e);
      m_inflight = 1;
      m_done = edge_n + 2 + s;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit req, input bit shuf);
    check("ready", int'(READY_O), int'(m_ready()));
    check("cards_left", int'(CARDS_LEFT_O), m_left);
    check("deck_empty", int'(DECK_EMPTY_O), int'(m_left == 0));
    REQ_I = req;
    SHUFFLE_I = shuf;
    @(posedge CLK);
    model_step(req, shuf);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    #2;
    RST_N = 1'b0;
    REQ_I = 1'b0;
    SHUFFLE_I = 1'b0;
    model_reset();
    #1;
    check("rst_valid", int'(CARD_VALID_O), 0);
    check("rst_card", int'(CARD_O), 0);
    check("rst_rank", int'(RANK_O), 0);
    check("rst_left", int'(CARDS_LEFT_O), FULL_LEFT);
    check("rst_empty", int'(DECK_EMPTY_O), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    log_q.delete();
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a card.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && CARD_VALID_O) begin
        n_strobe++;
        log_q.push_back(int'(RANK_O));
        if (RANK_O <= 4'd13) hist_rank[RANK_O]++;
        if (CARD_O <= 4'd10) hist_card[CARD_O]++;
        if (sb.size() == 0) begin
          check("strobe_expected", int'(CARD_VALID_O), 0);
        end else begin
          e = sb.pop_front();
          check("rank", int'(RANK_O), e.rank);
          check("card", int'(CARD_O), e.card);
          check("strobe_cycle", edge_n, e.cyc);
        end
      end
    end
  end

  initial begin
    int n_before;
    n_strobe = 0;
    @(negedge CLK);
    do_reset();
    check("ready_after_reset", int'(READY_O), 1);

    for (int i = 0; i < 10; i++) cycle(0, 0);
    check("idle_no_strobe", n_strobe, 0);

    // Full drain with request held high.
    for (int r = 0; r < 14; r++) hist_rank[r] = 0;
    for (int c = 0; c < 11; c++) hist_card[c] = 0;
    n_strobe = 0;
    for (int i = 0; i < 900 && !(m_left == 0 && !m_inflight); i++) cycle(1, 0);
    cycle(0, 0);
    check("drain_strobes", n_strobe, FULL_LEFT);
    for (int r = 1; r <= 13; r++) check("hist_rank", hist_rank[r], FULL_CNT);
    check("hist_card10", hist_card[10], 16 * ND);
    check("hist_card1", hist_card[1], FULL_CNT);
    check("empty_flag", int'(DECK_EMPTY_O), 1);
    check("empty_ready", int'(READY_O), 0);

    for (int i = 0; i < 5; i++) begin
      cycle(1, 0);
      cycle(0, 0);
    end
    check("empty_no_strobe", n_strobe, FULL_LEFT);
    check("empty_left", int'(CARDS_LEFT_O), 0);

    // Shuffle restores the shoe; then abort a draw in its DRAW cycle.
    cycle(0, 1);
    check("shuffle_left", int'(CARDS_LEFT_O), FULL_LEFT);
    for (int i = 0; i < 30; i++) cycle(1, 0);
    for (int i = 0; i < 20 && !m_ready(); i++) cycle(0, 0);
    n_before = n_strobe;
    cycle(1, 0);
    cycle(0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0);
    check("abort_no_strobe", n_strobe, n_before);
    check("abort_left", int'(CARDS_LEFT_O), FULL_LEFT);
    check("abort_ready", int'(READY_O), 1);
    cycle(1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0);
    check("same_cycle_drop", n_strobe, n_before);

    // Random requests with occasional shuffles, draining the shoe at times.
    for (int i = 0; i < 2500; i++)
      cycle(bit'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
    for (int i = 0; i < 20; i++) cycle(0, 0);

    // Reset asserted while a draw is in progress.
    for (int i = 0; i < 20 && !m_ready(); i++) cycle(0, 1);
    cycle(1, 0);
    do_reset();

    // Same seed across two resets gives the same rank sequence.
    for (int i = 0; i < 300 && log_q.size() < 8; i++) cycle(1, 0);
    run1 = log_q;
    do_reset();
    for (int i = 0; i < 300 && log_q.size() < 8; i++) cycle(1, 0);
    check("seed_run1_len", run1.size(), 8);
    check("seed_run2_len", log_q.size(), 8);
    for (int i = 0; i < 8 && i < run1.size() && i < log_q.size(); i++)
      check("seed_repeat", log_q[i], run1[i]);

    for (int i = 0; i < 20; i++) cycle(0, 0);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
